// File: rtl/dcache_wt.sv
// dcache_wt - direct-mapped, write-through, no-write-allocate data cache.
//
// Sits between the CPU load/store unit and a burst-capable main-memory port.
// Loads that hit return data one cycle after acceptance. Loads that miss
// refill the whole line with one burst read. Stores always go straight to
// memory as a single write with byte enables, and also update the cached
// word when they hit. A whole-cache invalidate clears one valid bit per cycle.
//
// Ports
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   dcache_addr         byte address of the request
//   dcache_in           store data, right-aligned
//   dcache_rdreq        load request
//   dcache_wrreq        store request (wins over a simultaneous load)
//   dcache_wordlen      0=byte, 1=halfword, 2/3=word
//   dcache_invalidate   clear all valid bits (wins over loads and stores)
//   dcache_busy         request cannot be accepted this cycle
//   dcache_out          load data, right-aligned and zero-extended
//   dcache_out_valid    one-cycle pulse qualifying dcache_out
//   mem_addr            word-aligned memory address
//   mem_in              store data on the memory byte lanes
//   mem_byteen          byte enables for mem_wrreq
//   mem_wrreq           one-cycle write strobe
//   mem_rdreq           one-cycle burst-read strobe
//   mem_burstlen        burst length, always LINEWORDS
//   mem_out             burst read data
//   mem_out_valid       qualifies each burst word, ascending order
module dcache_wt #(
    parameter int unsigned DATABITS  = 32,
    parameter int unsigned ADDRBITS  = 32,
    parameter int unsigned LINEWORDS = 8,
    parameter int unsigned LINES     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDRBITS-1:0]   dcache_addr,
    input  logic [DATABITS-1:0]   dcache_in,
    input  logic                  dcache_rdreq,
    input  logic                  dcache_wrreq,
    input  logic [1:0]            dcache_wordlen,
    input  logic                  dcache_invalidate,
    output logic                  dcache_busy,
    output logic [DATABITS-1:0]   dcache_out,
    output logic                  dcache_out_valid,
    output logic [ADDRBITS-1:0]   mem_addr,
    output logic [DATABITS-1:0]   mem_in,
    output logic [DATABITS/8-1:0] mem_byteen,
    output logic                  mem_wrreq,
    output logic                  mem_rdreq,
    output logic [15:0]           mem_burstlen,
    input  logic [DATABITS-1:0]   mem_out,
    input  logic                  mem_out_valid
);

    localparam int unsigned LANES   = DATABITS / 8;
    localparam int unsigned OFFBITS = $clog2(LINEWORDS);
    localparam int unsigned IDXBITS = $clog2(LINES);
    localparam int unsigned TAGBITS = ADDRBITS - IDXBITS - OFFBITS - 2;
    localparam int unsigned WORDS   = LINES * LINEWORDS;
    localparam int unsigned PTRBITS = IDXBITS + OFFBITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        INVAL = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Storage: data and tag arrays are plain memories, valid bits are reset flops
    logic [DATABITS-1:0] data_mem [WORDS];
    logic [TAGBITS-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]    valid;

    // Miss context captured at acceptance and used throughout the refill
    logic [TAGBITS-1:0]  req_tag;
    logic [IDXBITS-1:0]  req_idx;
    logic [OFFBITS-1:0]  req_off;
    logic [1:0]          req_byte;
    logic [1:0]          req_len;

    logic [OFFBITS-1:0]  fill_cnt;
    logic [IDXBITS-1:0]  inval_idx;

    logic [TAGBITS-1:0]  in_tag;
    logic [IDXBITS-1:0]  in_idx;
    logic [OFFBITS-1:0]  in_off;
    logic [1:0]          in_byte;
    logic [PTRBITS-1:0]  in_ptr;
    logic                hit;
    logic                accept_wr;
    logic                accept_rd;
    logic [LANES-1:0]    st_be;
    logic [DATABITS-1:0] st_data;
    logic [DATABITS-1:0] hit_word;
    logic [DATABITS-1:0] fill_word;
    logic                fill_we;
    logic                fill_done;
    logic                inval_step;

    // Address split and lookup
    assign in_byte  = dcache_addr[1:0];
    assign in_off   = dcache_addr[2 +: OFFBITS];
    assign in_idx   = dcache_addr[OFFBITS+2 +: IDXBITS];
    assign in_tag   = dcache_addr[ADDRBITS-1 -: TAGBITS];
    assign in_ptr   = {in_idx, in_off};
    assign hit      = valid[in_idx] && (tag_mem[in_idx] == in_tag);
    assign hit_word = data_mem[in_ptr];

    assign dcache_busy  = (state != IDLE) | dcache_invalidate;
    assign accept_wr    = (state == IDLE) && !dcache_invalidate && dcache_wrreq;
    assign accept_rd    = (state == IDLE) && !dcache_invalidate && !dcache_wrreq && dcache_rdreq;
    assign mem_burstlen = 16'(LINEWORDS);

    // The last burst word is not in the array yet, so take it from the bus
    assign fill_word = (req_off == fill_cnt) ? mem_out : data_mem[{req_idx, req_off}];

    // Right-aligned, zero-extended load extraction; halfword ignores addr[0]
    function automatic logic [DATABITS-1:0] load_align(input logic [DATABITS-1:0] w,
                                                       input logic [1:0] b,
                                                       input logic [1:0] len);
        logic [DATABITS-1:0] r;
        case (len)
            2'd0:    r = DATABITS'(w[{b, 3'b000} +: 8]);
            2'd1:    r = DATABITS'(w[{b[1], 4'b0000} +: 16]);
            default: r = w;
        endcase
        return r;
    endfunction

    // Store lane placement and byte enables
    always_comb begin
        st_be   = '1;
        st_data = dcache_in;
        case (dcache_wordlen)
            2'd0: begin
                st_be   = LANES'(1) << in_byte;
                st_data = DATABITS'(dcache_in[7:0]) << {in_byte, 3'b000};
            end
            2'd1: begin
                st_be   = in_byte[1] ? LANES'(4'b1100) : LANES'(4'b0011);
                st_data = DATABITS'(dcache_in[15:0]) << {in_byte[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_nxt  = state;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        inval_step = 1'b0;
        case (state)
            IDLE: begin
                if (dcache_invalidate)     state_nxt = INVAL;
                else if (accept_rd && !hit) state_nxt = FILL;
            end
            FILL: begin
                if (mem_out_valid) begin
                    fill_we = 1'b1;
                    if (fill_cnt == OFFBITS'(LINEWORDS - 1)) begin
                        fill_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            INVAL: begin
                inval_step = 1'b1;
                if (inval_idx == IDXBITS'(LINES - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data and tag arrays (no reset; validity is tracked by the valid flops)
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{req_idx, fill_cnt}] <= mem_out;
        end else if (accept_wr && hit) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (st_be[b]) data_mem[in_ptr][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
        if (fill_done) tag_mem[req_idx] <= req_tag;
    end

    // Registered outputs, counters, valid bits and miss context
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid            <= '0;
            fill_cnt         <= '0;
            inval_idx        <= '0;
            req_tag          <= '0;
            req_idx          <= '0;
            req_off          <= '0;
            req_byte         <= '0;
            req_len          <= '0;
            dcache_out       <= '0;
            dcache_out_valid <= 1'b0;
            mem_addr         <= '0;
            mem_in           <= '0;
            mem_byteen       <= '0;
            mem_wrreq        <= 1'b0;
            mem_rdreq        <= 1'b0;
        end else begin
            dcache_out_valid <= 1'b0;
            mem_wrreq        <= 1'b0;
            mem_rdreq        <= 1'b0;
            mem_in           <= '0;
            mem_byteen       <= '0;
            // mem_addr is held for the whole refill, zero otherwise
            if (state != FILL || fill_done) mem_addr <= '0;

            if (accept_wr) begin
                mem_wrreq  <= 1'b1;
                mem_addr   <= {dcache_addr[ADDRBITS-1:2], 2'b00};
                mem_in     <= st_data;
                mem_byteen <= st_be;
            end else if (accept_rd) begin
                if (hit) begin
                    dcache_out       <= load_align(hit_word, in_byte, dcache_wordlen);
                    dcache_out_valid <= 1'b1;
                end else begin
                    mem_rdreq <= 1'b1;
                    mem_addr  <= dcache_addr & ~ADDRBITS'(LINEWORDS * 4 - 1);
                    req_tag   <= in_tag;
                    req_idx   <= in_idx;
                    req_off   <= in_off;
                    req_byte  <= in_byte;
                    req_len   <= dcache_wordlen;
                    fill_cnt  <= '0;
                end
            end

            if (fill_we) fill_cnt <= fill_cnt + OFFBITS'(1);
            if (fill_done) begin
                valid[req_idx]   <= 1'b1;
                dcache_out       <= load_align(fill_word, req_byte, req_len);
                dcache_out_valid <= 1'b1;
            end

            if (state == IDLE && dcache_invalidate) inval_idx <= '0;
            if (inval_step) begin
                valid[inval_idx] <= 1'b0;
                inval_idx        <= inval_idx + IDXBITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt - directed, scoreboarded bench for dcache_wt.
// A behavioural main memory (1-cycle write, burst starting 1 cycle after
// mem_rdreq) serves the DUT; a separate reference memory, updated as stores
// are issued, supplies expected load data.
`timescale 1ns/1ps
module tb_dcache_wt;

    localparam int unsigned LW = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dcache_addr = '0;
    logic [31:0] dcache_in = '0;
    logic        dcache_rdreq = 1'b0;
    logic        dcache_wrreq = 1'b0;
    logic [1:0]  dcache_wordlen = 2'd2;
    logic        dcache_invalidate = 1'b0;
    logic        dcache_busy;
    logic [31:0] dcache_out;
    logic        dcache_out_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic [3:0]  mem_byteen;
    logic        mem_wrreq;
    logic        mem_rdreq;
    logic [15:0] mem_burstlen;
    logic [31:0] mem_out = '0;
    logic        mem_out_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dcache_wt #(.DATABITS(32), .ADDRBITS(32), .LINEWORDS(LW), .LINES(64)) dut (
        .clk(clk), .reset(reset),
        .dcache_addr(dcache_addr), .dcache_in(dcache_in),
        .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
        .dcache_wordlen(dcache_wordlen), .dcache_invalidate(dcache_invalidate),
        .dcache_busy(dcache_busy), .dcache_out(dcache_out),
        .dcache_out_valid(dcache_out_valid),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_byteen(mem_byteen),
        .mem_wrreq(mem_wrreq), .mem_rdreq(mem_rdreq), .mem_burstlen(mem_burstlen),
        .mem_out(mem_out), .mem_out_valid(mem_out_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memories keyed by word address; unwritten words have a fixed pattern
    logic [31:0] ref_mem  [int unsigned];
    logic [31:0] main_mem [int unsigned];

    function automatic logic [31:0] init_word(input int unsigned wa);
        return 32'h5a000000 | 32'(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input int unsigned wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] main_rd(input int unsigned wa);
        return main_mem.exists(wa) ? main_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] len);
        logic [31:0] w;
        int sh;
        w = ref_rd(int'(a >> 2));
        case (len)
            2'd0:    begin sh = 8 * int'(a[1:0]);    return (w >> sh) & 32'h000000ff; end
            2'd1:    begin sh = a[1] ? 16 : 0;       return (w >> sh) & 32'h0000ffff; end
            default: return w;
        endcase
    endfunction

    // Scoreboard queues and monitor state
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    int          outs_seen = 0;
    int          wr_count = 0;
    int          rd_count = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] exp_v;
    wr_t         exp_w;
    logic [31:0] cur_w;

    // Output monitor: pops expectations as the DUT produces results
    always @(negedge clk) begin
        if (!reset) begin
            if (dcache_out_valid) begin
                outs_seen++;
                if (rd_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(dcache_out_valid), 32'd0);
                end else begin
                    exp_v = rd_q.pop_front();
                    check("load_data", dcache_out, exp_v);
                end
            end
            if (mem_wrreq) begin
                wr_count++;
                if (wr_q.size() == 0) begin
                    check("unexpected_mem_wrreq", 32'(mem_wrreq), 32'd0);
                end else begin
                    exp_w = wr_q.pop_front();
                    check("wr_addr", mem_addr, exp_w.addr);
                    check("wr_data", mem_in, exp_w.data);
                    check("wr_byteen", 32'(mem_byteen), 32'(exp_w.be));
                end
            end else begin
                check("idle_mem_in", mem_in, 32'd0);
                check("idle_mem_byteen", 32'(mem_byteen), 32'd0);
            end
            if (mem_rdreq) begin
                rd_count++;
                last_rd_addr = mem_addr;
                check("burstlen", 32'(mem_burstlen), 32'(LW));
            end
            check("strobe_exclusive", 32'(mem_rdreq & mem_wrreq), 32'd0);
        end
    end

    // Main memory: applies writes, streams bursts starting one cycle after mem_rdreq
    bit          burst_pending = 1'b0;
    int          burst_left = 0;
    int unsigned burst_wa = 0;
    int          burst_words = 0;

    always @(negedge clk) begin
        if (!reset && mem_wrreq) begin
            cur_w = main_rd(int'(mem_addr >> 2));
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) cur_w[8*b +: 8] = mem_in[8*b +: 8];
            main_mem[int'(mem_addr >> 2)] = cur_w;
        end
        if (!reset && mem_rdreq) begin
            burst_pending = 1'b1;
            burst_wa = int'(mem_addr >> 2);
        end
    end

    always @(posedge clk) begin
        #1;
        mem_out_valid = 1'b0;
        mem_out = '0;
        if (burst_pending) begin
            burst_pending = 1'b0;
            burst_left = int'(LW);
        end
        if (burst_left > 0) begin
            mem_out = main_rd(burst_wa);
            mem_out_valid = 1'b1;
            burst_wa++;
            burst_left--;
            burst_words++;
        end
    end

    // Holds the currently driven request until a non-busy edge accepts it
    task automatic wait_accept(output int waited, output bit acc);
        waited = 0;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = !dcache_busy;
            if (!acc) waited++;
            @(posedge clk);
            #1;
            dcache_invalidate = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] len, output int waited);
        int          lane;
        logic [3:0]  be;
        logic [31:0] lanes;
        logic [31:0] cur;
        wr_t         w;
        bit          acc;
        case (len)
            2'd0:    begin lane = int'(a[1:0]); be = 4'(1 << lane); lanes = (d & 32'h000000ff) << (8 * lane); end
            2'd1:    begin lane = a[1] ? 2 : 0; be = 4'(3 << lane); lanes = (d & 32'h0000ffff) << (8 * lane); end
            default: begin lane = 0; be = 4'hf; lanes = d; end
        endcase
        cur = ref_rd(int'(a >> 2));
        for (int b = 0; b < 4; b++)
            if (be[b]) cur[8*b +: 8] = lanes[8*b +: 8];
        ref_mem[int'(a >> 2)] = cur;
        w.addr = a & 32'hfffffffc;
        w.data = lanes;
        w.be   = be;
        wr_q.push_back(w);
        dcache_addr = a;
        dcache_in = d;
        dcache_wordlen = len;
        dcache_wrreq = 1'b1;
        wait_accept(waited, acc);
        dcache_wrreq = 1'b0;
        check("write_accepted", 32'(acc), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] len, input bit inval,
                           output int waited, output int lat);
        bit acc;
        int seen0;
        rd_q.push_back(exp_load(a, len));
        dcache_addr = a;
        dcache_wordlen = len;
        dcache_rdreq = 1'b1;
        dcache_invalidate = inval;
        wait_accept(waited, acc);
        dcache_rdreq = 1'b0;
        check("read_accepted", 32'(acc), 32'd1);
        seen0 = outs_seen;
        lat = 0;
        while (outs_seen == seen0 && lat < 40) begin
            @(posedge clk);
            lat++;
        end
        #1;
        check("read_response", 32'(outs_seen - seen0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        int lat;
        int outs_before;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(dcache_busy), 32'd0);
        check("rst_out", dcache_out, 32'd0);
        check("rst_out_valid", 32'(dcache_out_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_in", mem_in, 32'd0);
        check("rst_mem_byteen", 32'(mem_byteen), 32'd0);
        check("rst_mem_wrreq", 32'(mem_wrreq), 32'd0);
        check("rst_mem_rdreq", 32'(mem_rdreq), 32'd0);
        check("rst_burstlen", 32'(mem_burstlen), 32'd8);
        @(posedge clk);
        #1;

        // Back-to-back store misses: one write per cycle, never busy
        for (int i = 0; i < 8; i++) begin
            do_write(32'h80 + 32'(4 * i), 32'h0fff0001 + 32'(i), 2'd2, waited);
            check("store_busy_wait", 32'(waited), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("store_wr_count", 32'(wr_count), 32'd8);
        check("store_no_rdreq", 32'(rd_count), 32'd0);

        // Miss then hits on the same line
        do_read(32'h80, 2'd2, 1'b0, waited, lat);
        check("miss_rdreq_count", 32'(rd_count), 32'd1);
        check("miss_line_addr", last_rd_addr, 32'h80);
        check("miss_latency", 32'(lat), 32'(LW + 2));
        for (int i = 1; i < 8; i++) begin
            do_read(32'h80 + 32'(4 * i), 2'd2, 1'b0, waited, lat);
            check("hit_latency", 32'(lat), 32'd1);
        end
        check("hit_no_rdreq", 32'(rd_count), 32'd1);

        // Byte store hit, then merged reads of each size
        do_write(32'h81, 32'h000000ab, 2'd0, waited);
        do_read(32'h80, 2'd2, 1'b0, waited, lat);
        check("merge_word_latency", 32'(lat), 32'd1);
        do_read(32'h83, 2'd0, 1'b0, waited, lat);
        do_read(32'h82, 2'd1, 1'b0, waited, lat);
        check("merge_no_rdreq", 32'(rd_count), 32'd1);

        // Simultaneous read and write: only the write happens
        outs_before = outs_seen;
        dcache_rdreq = 1'b1;
        do_write(32'h200, 32'h12345678, 2'd2, waited);
        dcache_rdreq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rw_no_rdreq", 32'(rd_count), 32'd1);
        check("rw_no_out", 32'(outs_seen - outs_before), 32'd0);

        // Conflicting line evicts, and the original line misses again
        do_read(32'h880, 2'd2, 1'b0, waited, lat);
        check("conflict_rdreq", 32'(rd_count), 32'd2);
        check("conflict_addr", last_rd_addr, 32'h880);
        do_read(32'h80, 2'd2, 1'b0, waited, lat);
        check("refetch_rdreq", 32'(rd_count), 32'd3);
        check("refetch_addr", last_rd_addr, 32'h80);

        // Invalidate with a read held alongside it
        do_read(32'h84, 2'd2, 1'b1, waited, lat);
        check("inval_busy_cycles", 32'(waited), 32'd65);
        check("inval_read_misses", 32'(rd_count), 32'd4);
        check("inval_miss_latency", 32'(lat), 32'(LW + 2));

        // Misaligned halfword store hit, then reads
        do_write(32'h87, 32'h0000beef, 2'd1, waited);
        do_read(32'h84, 2'd2, 1'b0, waited, lat);
        check("half_merge_latency", 32'(lat), 32'd1);
        do_read(32'h85, 2'd1, 1'b0, waited, lat);
        check("half_no_rdreq", 32'(rd_count), 32'd4);

        // Reset after three of the eight refill words
        burst_words = 0;
        outs_before = outs_seen;
        dcache_addr = 32'h880;
        dcache_wordlen = 2'd2;
        dcache_rdreq = 1'b1;
        @(posedge clk);
        #1;
        dcache_rdreq = 1'b0;
        n = 0;
        while (burst_words < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("abort_fill_started", 32'(burst_words >= 3), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(dcache_busy), 32'd0);
        check("abort_out_valid", 32'(dcache_out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_out", 32'(outs_seen - outs_before), 32'd0);
        check("abort_rdreq_count", 32'(rd_count), 32'd5);

        do_read(32'h84, 2'd2, 1'b0, waited, lat);
        check("post_abort_rdreq", 32'(rd_count), 32'd6);
        check("post_abort_addr", last_rd_addr, 32'h80);
        check("post_abort_latency", 32'(lat), 32'(LW + 2));

        // Miss on the last word of a line
        do_read(32'h11c, 2'd2, 1'b0, waited, lat);
        check("lastword_rdreq", 32'(rd_count), 32'd7);
        check("lastword_addr", last_rd_addr, 32'h100);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
